struct_lane_write_arb: RTL and testbench
========================================

// Module: struct_lane_write_arb
// PURPOSE
//  Arbitrates two requesters writing into one shared packed config struct.
//  The struct is an NLANES-byte packed array 'a' above a 16-bit field 'b'.
//  Multi-lane writes to 'a' are serialised one byte lane per cycle.
//  A write to 'b' takes one cycle. The struct is exported flat as cfg_q.
// PARAMETERS
//  NLANES  8  number of byte lanes in field a (1..8); cfg_q width = NLANES*8+16
// PORTS
//  clk        in   1          clock
//  rst        in   1          asynchronous, active-high reset
//  clear      in   1          sync clear of cfg_q; aborts any transfer
//  req_valid  in   [1:0]      per-requester request valid
//  req_ready  out  [1:0]      per-requester accept (one-hot or zero)
//  req_sel    in   [1:0]      per-requester target: 0 = field a, 1 = field b
//  req_idx    in   [1:0][2:0] start lane in a (ignored for b)
//  req_len    in   [1:0][2:0] lane count minus 1 (ignored for b)
//  req_data   in   [1:0][63:0] byte k = data[8k+7:8k]; b uses data[15:0]
//  cfg_q      out  NLANES*8+16 registered struct image
//  done       out  1          one-cycle pulse after the final write of a transfer
//  err        out  1          pulses with done if any lane was out of range
//  gnt_id     out  1          requester that owns the current/last transfer
// BEHAVIOUR
//  - Reset (async, rst=1):
//    - cfg_q='0, done=0, err=0, gnt_id=0, state=IDLE.
//    - Round-robin pointer prefers requester 0.
//    - req_ready is 0 while rst is high.
//  - Layout:
//    - b = cfg_q[15:0]; a[i] = cfg_q[16+8i+7 : 16+8i].
//    - a[NLANES-1] sits at the MSBs.
//  - States are IDLE and BUSY.
//  - IDLE:
//    - req_ready is combinational. It asserts for exactly one valid requester.
//    - With both valid, the requester not equal to gnt_id wins.
//    - A handshake (valid & ready) captures sel/idx/len/data, sets gnt_id, and moves to BUSY.
//    - Nothing is written in the handshake cycle.
//  - BUSY, sel=a:
//    - Cycle k (k=0..len) writes a[idx+k] <= data byte k.
//    - After the len cycle the block returns to IDLE.
//    - Latency: handshake at T, lanes written at T+1..T+1+len, done high at T+2+len.
//  - BUSY, sel=b: writes b <= data[15:0] at T+1; done at T+2.
//  - req_ready=0 in BUSY. The next handshake is possible in the cycle done is high.
//  - Out of range: lane idx+k >= NLANES is not written (no wrap). Its cycle is still spent, and err pulses with done.
//  - clear has priority over every write:
//    - cfg_q <= '0, state <= IDLE, no done/err, req_ready=0 that cycle.
//    - The round-robin pointer is retained.
//  - Mid-transfer rst: lanes already written are lost with the reset. No done.
//  - Inputs need only be stable in the handshake cycle; captured copies are used afterwards.
// STRUCTURE
//  - Package struct_lane_pkg:
//    - parameterised typedef cfg_s {logic [NLANES-1:0][7:0] a; logic [15:0] b;}
//    - state enum {IDLE, BUSY}
//    - localparam B_W=16
//  - Sub-module rr_arb2: two-way round-robin grant with last-winner pointer.
//  - All remaining logic is one always_ff plus one always_comb in this module.
// TESTING
//  1) Reset, then req0 a idx=1 len=1 data=16'h1234 -> cfg_q=80'h0000_0000_0012_3400_0000; done at T+3.
//  2) Then req1 a idx=5 len=0 data=8'h42, then b data=16'hFFFC -> cfg_q=80'h0000_4200_0012_3400_FFFC.
//  3) Both valid every cycle (req0 a[7]<=FC, req1 a[6]<=00) -> grants alternate 1,0,1...;
//     final cfg_q=80'hFC00_4200_0012_3400_FFFC.
//  4) idx=6 len=3 data=32'hDDCC_BBAA -> a[6]=AA, a[7]=BB; lanes 8,9 dropped; 4 write cycles; err=1 with done.
//  5) clear asserted during the 2nd cycle of a len=3 transfer -> cfg_q=0 next edge; no done; req_ready back next cycle.
//  6) rst asserted mid-transfer (asynchronously, off clock edge) -> cfg_q=0 immediately; IDLE; first grant goes to req0.

Source files
------------

// File: rtl/struct_lane_write_arb_pkg.sv
// Shared types and constants for the lane-serialised config write arbiter.
// The struct type itself is declared inside the top module, because a package
// cannot take the NLANES parameter.
package struct_lane_pkg;

  localparam int B_W       = 16;  // width of field b
  localparam int LANE_W    = 8;   // one byte lane of field a
  localparam int DATA_W    = 64;  // request data word
  localparam int MAX_LANES = 8;   // widest field a that idx/len can address

  // Request target select
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Byte k of a request data word
  function automatic logic [LANE_W-1:0] lane_byte(input logic [DATA_W-1:0] data,
                                                  input logic [2:0]        k);
    return data[{k, 3'b000} +: LANE_W];
  endfunction

endpackage

// File: rtl/struct_lane_write_arb_if.sv
// Request bus of the two requesters.
// The requesters drive valid, sel, idx, len and data. The arbiter drives a
// one-hot-or-zero ready.
interface struct_lane_write_arb_if;

  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_sel;
  logic [1:0][2:0]  req_idx;
  logic [1:0][2:0]  req_len;
  logic [1:0][63:0] req_data;

  modport master (
    output req_valid, req_sel, req_idx, req_len, req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_sel, req_idx, req_len, req_data,
    output req_ready
  );

endinterface

// File: rtl/struct_lane_write_arb_rr_arb2.sv
// Purpose: two-way round-robin grant. When both requesters are valid, the one
//   that did not win last time gets the grant.
// Latency: the grant is combinational from req/en, and the pointer updates on the granted edge.
// Backpressure: en low forces the grant to zero. The pointer moves only on a grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  // Last winner. It resets to 1 so that requester 0 is preferred first.
  logic last_q;

  // Grant selection: a lone requester wins; a tie goes to the non-last winner
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Remember the winner of each accepted grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (|gnt) begin
      last_q <= gnt[1];
    end
  end

endmodule

// File: rtl/struct_lane_write_arb.sv
// Purpose: arbitrates two requesters writing one shared packed config struct
//   {a[NLANES] bytes, b[15:0]}. Writes to a are serialised one lane per cycle.
// Latency: handshake at T, lanes are written at T+1..T+1+len, and done pulses at T+2+len.
// Backpressure: req_ready is low while busy, in reset, or during clear. A new
//   handshake is possible in the cycle that done is high.
module struct_lane_write_arb
  import struct_lane_pkg::*;
#(
  parameter int NLANES = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  struct_lane_write_arb_if.slave   req,
  output logic [NLANES*8+B_W-1:0]  cfg_q,
  output logic                     done,
  output logic                     err,
  output logic                     gnt_id
);

  typedef struct packed {
    logic [NLANES-1:0][LANE_W-1:0] a;
    logic [B_W-1:0]                b;
  } cfg_s;

  cfg_s                cfg_r;
  state_e              state_q;
  logic                sel_q;
  logic [2:0]          idx_q;
  logic [2:0]          len_q;
  logic [2:0]          k_q;
  logic [DATA_W-1:0]   data_q;
  logic                oor_acc_q;

  logic [1:0]          gnt;
  logic                arb_en;
  logic                win;
  logic [3:0]          lane;
  logic                lane_oor;
  logic                last_lane;
  logic [LANE_W-1:0]   byte_k;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req.req_valid),
    .en  (arb_en),
    .gnt (gnt)
  );

  assign req.req_ready = gnt;
  assign cfg_q         = cfg_r;

  // Arbitration enable and decode of the lane being written this cycle
  always_comb begin
    arb_en    = (state_q == IDLE) && !clear && !rst;
    win       = gnt[1];
    lane      = {1'b0, idx_q} + {1'b0, k_q};
    lane_oor  = (lane >= 4'(NLANES));
    last_lane = (k_q == len_q);
    byte_k    = lane_byte(data_q, k_q);
  end

  // Capture on handshake, then serialise lane writes. clear overrides all writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_r     <= '0;
      state_q   <= IDLE;
      sel_q     <= SEL_A;
      idx_q     <= '0;
      len_q     <= '0;
      k_q       <= '0;
      data_q    <= '0;
      oor_acc_q <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      gnt_id    <= 1'b0;
    end else if (clear) begin
      cfg_r     <= '0;
      state_q   <= IDLE;
      k_q       <= '0;
      oor_acc_q <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|gnt) begin
            sel_q     <= req.req_sel[win];
            idx_q     <= req.req_idx[win];
            len_q     <= req.req_len[win];
            data_q    <= req.req_data[win];
            gnt_id    <= win;
            k_q       <= '0;
            oor_acc_q <= 1'b0;
            state_q   <= BUSY;
          end
        end
        BUSY: begin
          if (sel_q == SEL_B) begin
            cfg_r.b <= data_q[B_W-1:0];
            done    <= 1'b1;
            state_q <= IDLE;
          end else begin
            // Lanes past the top of a are dropped. No wrap is applied, but the cycle is still spent.
            for (int i = 0; i < NLANES; i++) begin
              if (lane == 4'(i)) cfg_r.a[i] <= byte_k;
            end
            if (last_lane) begin
              done    <= 1'b1;
              err     <= oor_acc_q | lane_oor;
              state_q <= IDLE;
            end else begin
              k_q       <= k_q + 3'd1;
              oor_acc_q <= oor_acc_q | lane_oor;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_struct_lane_write_arb.sv
// Directed bench for struct_lane_write_arb with NLANES=8 and an 80-bit cfg_q.
module tb_struct_lane_write_arb;
  import struct_lane_pkg::*;

  logic        clk;
  logic        rst;
  logic        clear;
  logic [79:0] cfg_q;
  logic        done;
  logic        err;
  logic        gnt_id;

  int n_chk;
  int n_fail;
  int done_cnt;

  struct_lane_write_arb_if bus ();

  struct_lane_write_arb #(.NLANES(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .req    (bus),
    .cfg_q  (cfg_q),
    .done   (done),
    .err    (err),
    .gnt_id (gnt_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int r, input logic v, input logic sel, input logic [2:0] idx,
                         input logic [2:0] len, input logic [63:0] data);
    bus.req_valid[r] = v;
    bus.req_sel[r]   = sel;
    bus.req_idx[r]   = idx;
    bus.req_len[r]   = len;
    bus.req_data[r]  = data;
  endtask

  // Bounded wait for ready[r] that samples just after each negedge. It returns after the handshake edge.
  task automatic wait_hs(input int r, input string tag);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (bus.req_ready[r]) got = 1'b1;
      else @(negedge clk);
    end
    chk({tag, "_hs"}, got, 1'b1);
    @(posedge clk);
  endtask

  // Bounded wait for done. It reports the latency in negedges after the handshake edge, and the err value seen.
  task automatic wait_done(input string tag, output int lat, output logic e);
    logic found;
    found = 1'b0;
    lat   = 99;
    e     = 1'b0;
    for (int n = 1; n <= 40 && !found; n++) begin
      @(negedge clk);
      if (n == 1) chk({tag, "_busy_rdy"}, bus.req_ready, 2'b00);
      if (done) begin
        found = 1'b1;
        lat   = n;
        e     = err;
      end
    end
  endtask

  // One single-requester transfer. Inputs are scrambled right after the handshake.
  task automatic xfer(input int r, input logic sel, input logic [2:0] idx, input logic [2:0] len,
                      input logic [63:0] data, input string tag, output int lat, output logic e);
    @(negedge clk);
    set_req(r, 1'b1, sel, idx, len, data);
    wait_hs(r, tag);
    #1;
    set_req(r, 1'b0, ~sel, ~idx, ~len, ~data);
    wait_done(tag, lat, e);
  endtask

  initial begin
    int   lat;
    logic e;
    int   ng;
    logic g [4];
    int   dc0;

    n_chk    = 0;
    n_fail   = 0;
    done_cnt = 0;
    clear    = 1'b0;
    rst      = 1'b1;
    set_req(0, 1'b1, SEL_A, 3'd0, 3'd0, 64'h0);
    set_req(1, 1'b1, SEL_A, 3'd0, 3'd0, 64'h0);

    // Reset state; ready must stay low while rst is high
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rdy",    bus.req_ready, 2'b00);
    chk("rst_cfg",    cfg_q, 80'h0);
    chk("rst_done",   done, 1'b0);
    chk("rst_err",    err, 1'b0);
    chk("rst_gnt_id", gnt_id, 1'b0);
    bus.req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b0;

    // 1) req0 a idx=1 len=1 -> a[1]=34 a[2]=12, done at T+3
    xfer(0, SEL_A, 3'd1, 3'd1, 64'h1234, "t1", lat, e);
    chk("t1_lat", lat, 3);
    chk("t1_err", e, 1'b0);
    chk("t1_cfg", cfg_q, 80'h0000_0000_0012_3400_0000);
    chk("t1_gnt", gnt_id, 1'b0);

    // 2) req1 a[5]=42, then req0 b=FFFC (upper data bits must be ignored)
    xfer(1, SEL_A, 3'd5, 3'd0, 64'h42, "t2a", lat, e);
    chk("t2a_lat", lat, 2);
    chk("t2a_gnt", gnt_id, 1'b1);
    xfer(0, SEL_B, 3'd7, 3'd7, 64'hAAAA_5555_0000_FFFC, "t2b", lat, e);
    chk("t2b_lat", lat, 2);
    chk("t2b_err", e, 1'b0);
    chk("t2_cfg", cfg_q, 80'h0000_4200_0012_3400_FFFC);
    chk("t2b_gnt", gnt_id, 1'b0);

    // 3) Both requesters valid continuously: grants alternate 1,0,1,0
    @(negedge clk);
    set_req(0, 1'b1, SEL_A, 3'd7, 3'd0, 64'hFC);
    set_req(1, 1'b1, SEL_A, 3'd6, 3'd0, 64'h00);
    ng = 0;
    for (int i = 0; i < 40 && ng < 4; i++) begin
      #1;
      if (|bus.req_ready) begin
        chk("t3_onehot", $onehot(bus.req_ready), 1'b1);
        g[ng] = bus.req_ready[1];
        ng++;
        if (ng == 4) begin
          @(posedge clk);
          #1;
          bus.req_valid = 2'b00;
        end
      end
      if (ng < 4) @(negedge clk);
    end
    chk("t3_ngrants", ng, 4);
    chk("t3_g0", g[0], 1'b1);
    chk("t3_g1", g[1], 1'b0);
    chk("t3_g2", g[2], 1'b1);
    chk("t3_g3", g[3], 1'b0);
    wait_done("t3", lat, e);
    chk("t3_lat", lat, 2);
    chk("t3_cfg", cfg_q, 80'hFC00_4200_0012_3400_FFFC);
    chk("t3_gnt", gnt_id, 1'b0);

    // 4) idx=6 len=3: lanes 6 and 7 are written, 8 and 9 are dropped, 4 cycles, err with done
    xfer(0, SEL_A, 3'd6, 3'd3, 64'hDDCC_BBAA, "t4", lat, e);
    chk("t4_lat", lat, 5);
    chk("t4_err", e, 1'b1);
    chk("t4_cfg", cfg_q, 80'hBBAA_4200_0012_3400_FFFC);

    // 5) clear in the 2nd busy cycle of a len=3 transfer
    @(negedge clk);
    set_req(0, 1'b1, SEL_A, 3'd0, 3'd3, 64'h1122_3344);
    wait_hs(0, "t5");
    #1;
    set_req(0, 1'b1, SEL_A, 3'd0, 3'd0, 64'h0);
    @(negedge clk);
    #1;
    chk("t5_busy_rdy", bus.req_ready, 2'b00);
    @(negedge clk);
    chk("t5_lane0", cfg_q, 80'hBBAA_4200_0012_3444_FFFC);
    dc0   = done_cnt;
    clear = 1'b1;
    #1;
    chk("t5_clr_rdy", bus.req_ready, 2'b00);
    @(negedge clk);
    clear = 1'b0;
    chk("t5_cfg", cfg_q, 80'h0);
    chk("t5_done", done, 1'b0);
    #1;
    chk("t5_rdy_back", bus.req_ready, 2'b01);
    bus.req_valid = 2'b00;
    repeat (4) @(negedge clk);
    chk("t5_no_done", done_cnt, dc0);

    // 6) asynchronous rst off the clock edge in the middle of a transfer
    @(negedge clk);
    set_req(0, 1'b1, SEL_A, 3'd0, 3'd3, 64'h0102_0304);
    wait_hs(0, "t6");
    #1;
    bus.req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("t6_pre_cfg", cfg_q, 80'h0000_0000_0000_0304_0000);
    dc0 = done_cnt;
    #3;
    rst = 1'b1;
    set_req(0, 1'b1, SEL_A, 3'd2, 3'd0, 64'h5A);
    set_req(1, 1'b1, SEL_A, 3'd3, 3'd0, 64'h77);
    #1;
    chk("t6_cfg", cfg_q, 80'h0);
    chk("t6_rst_rdy", bus.req_ready, 2'b00);
    chk("t6_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_first_gnt", bus.req_ready, 2'b01);
    @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
    chk("t6_no_done", done_cnt, dc0);
    wait_done("t6b", lat, e);
    chk("t6b_lat", lat, 2);
    chk("t6b_cfg", cfg_q, 80'h0000_0000_005A_0000_0000);
    chk("t6b_gnt", gnt_id, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
